// File: rtl/return_addr_stack.sv
// Purpose : per-thread return-address stack for fetch next-PC prediction (push on call, pop on return).
// Latency : one cycle; inputs sampled at edge N, registered outputs valid after edge N.
// Backpr. : i_Stall freezes every pointer, count, entry and output (pulses included).
//
// Ports:
//   i_Clk, i_Reset_n (sync, active-low), i_Stall
//   i_thread / i_push / i_pop / i_address : operation request for the selected thread
//   o_address / o_valid : popped entry; o_overflow / o_underflow : 1-cycle event pulses
//   o_depth : post-operation occupancy of the thread just operated on
//   o_err_count : saturating overflow+underflow event count (only with RAS_ERR_CNT_EN defined)
module return_addr_stack #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int STACK_DEPTH   = 16,
  parameter int NUM_THREADS   = 4,
  parameter int THREAD_WIDTH  = 2,
  parameter int PTR_WIDTH     = 4,
  parameter int CNT_WIDTH     = 5
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_Stall,
  input  logic [THREAD_WIDTH-1:0]  i_thread,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic                     o_valid,
  output logic                     o_overflow,
  output logic                     o_underflow,
  output logic [CNT_WIDTH-1:0]     o_depth
`ifdef RAS_ERR_CNT_EN
  ,
  output logic [15:0]              o_err_count
`endif
);

  // Entry storage is deliberately not reset; only pointers and counts are.
  logic [ADDRESS_WIDTH-1:0] mem [NUM_THREADS][STACK_DEPTH];
  logic [PTR_WIDTH-1:0]     tp  [NUM_THREADS];
  logic [CNT_WIDTH-1:0]     cnt [NUM_THREADS];

  logic [PTR_WIDTH-1:0]     cur_tp;
  logic [CNT_WIDTH-1:0]     cur_cnt;
  logic                     empty;
  logic                     full;
  logic                     pop_hit;
  logic                     underflow;
  logic                     overflow;
  logic [PTR_WIDTH-1:0]     wr_ptr;
  logic [PTR_WIDTH-1:0]     tp_nxt;
  logic [CNT_WIDTH-1:0]     cnt_nxt;
  logic [ADDRESS_WIDTH-1:0] rd_dat;

  always_comb begin
    cur_tp    = tp[i_thread];
    cur_cnt   = cnt[i_thread];
    rd_dat    = mem[i_thread][cur_tp];
    empty     = (cur_cnt == '0);
    full      = (cur_cnt == CNT_WIDTH'(STACK_DEPTH));
    pop_hit   = i_pop && !empty;
    underflow = i_pop && empty;
    // A combined push+pop on a non-empty stack replaces the top, so it can never overflow.
    overflow  = i_push && !pop_hit && full;
    // Replace-in-place for return-then-call; otherwise the push lands above the top.
    wr_ptr    = pop_hit ? cur_tp : cur_tp + PTR_WIDTH'(1);

    tp_nxt  = cur_tp;
    cnt_nxt = cur_cnt;
    if (i_push && pop_hit) begin
      tp_nxt  = cur_tp;
      cnt_nxt = cur_cnt;
    end else if (i_push) begin
      // Covers push+pop on empty too: the underflow is flagged, then it acts as a push.
      tp_nxt  = cur_tp + PTR_WIDTH'(1);
      cnt_nxt = full ? cur_cnt : cur_cnt + CNT_WIDTH'(1);
    end else if (pop_hit) begin
      tp_nxt  = cur_tp - PTR_WIDTH'(1);
      cnt_nxt = cur_cnt - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        tp[t]  <= '0;
        cnt[t] <= '0;
      end
      o_address   <= '0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
      o_depth     <= '0;
    end else if (!i_Stall) begin
      tp[i_thread]  <= tp_nxt;
      cnt[i_thread] <= cnt_nxt;
      o_valid       <= pop_hit;
      o_overflow    <= overflow;
      o_underflow   <= underflow;
      o_depth       <= cnt_nxt;
      if (pop_hit) begin
        o_address <= rd_dat;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset_n && !i_Stall && i_push) begin
      mem[i_thread][wr_ptr] <= i_address;
    end
  end

`ifdef RAS_ERR_CNT_EN
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      o_err_count <= '0;
    end else if (!i_Stall && (overflow || underflow) && (o_err_count != 16'hFFFF)) begin
      o_err_count <= o_err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_return_addr_stack.sv
// Purpose : self-checking bench for return_addr_stack against a bounded-stack reference model.
// Latency : checks every output 1 time unit after each rising edge.
// Backpr. : exercises i_Stall holds and reset taking priority over stall.
module tb_return_addr_stack;

  localparam int AW = 22;
  localparam int D  = 16;
  localparam int NT = 4;
  localparam int TW = 2;
  localparam int PW = 4;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic [TW-1:0] thread = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [AW-1:0] o_address;
  logic          o_valid;
  logic          o_overflow;
  logic          o_underflow;
  logic [CW-1:0] o_depth;

  int tests = 0;
  int fails = 0;

  // Reference model: each thread is a plain array with the oldest entry at index 0
  // and the newest at index sz-1; overflow shifts out index 0.
  logic [AW-1:0] stk [NT][D];
  int            sz  [NT];
  logic [AW-1:0] m_addr;
  logic          m_valid, m_ovf, m_udf;
  int            m_depth;

  return_addr_stack #(
    .ADDRESS_WIDTH(AW), .STACK_DEPTH(D), .NUM_THREADS(NT),
    .THREAD_WIDTH(TW), .PTR_WIDTH(PW), .CNT_WIDTH(CW)
  ) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Stall(stall), .i_thread(thread),
    .i_push(push), .i_pop(pop), .i_address(addr),
    .o_address(o_address), .o_valid(o_valid), .o_overflow(o_overflow),
    .o_underflow(o_underflow), .o_depth(o_depth)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit s, input int t, input bit pu, input bit po,
                       input logic [AW-1:0] a);
    if (!r) begin
      for (int i = 0; i < NT; i++) sz[i] = 0;
      m_addr = '0; m_valid = 0; m_ovf = 0; m_udf = 0; m_depth = 0;
    end else if (!s) begin
      m_valid = 0; m_ovf = 0; m_udf = 0;
      if (po) begin
        if (sz[t] > 0) begin
          sz[t]--;
          m_addr  = stk[t][sz[t]];
          m_valid = 1;
        end else begin
          m_udf = 1;
        end
      end
      if (pu) begin
        if (sz[t] == D) begin
          for (int i = 0; i < D - 1; i++) stk[t][i] = stk[t][i+1];
          stk[t][D-1] = a;
          m_ovf = 1;
        end else begin
          stk[t][sz[t]] = a;
          sz[t]++;
        end
      end
      m_depth = sz[t];
    end
  endtask

  task automatic step(input bit r, input bit s, input int t, input bit pu, input bit po,
                      input logic [AW-1:0] a);
    @(negedge clk);
    rst_n = r; stall = s; thread = TW'(t); push = pu; pop = po; addr = a;
    @(posedge clk);
    #1;
    model(r, s, t, pu, po, a);
    chk("o_valid", 32'(o_valid), 32'(m_valid));
    chk("o_overflow", 32'(o_overflow), 32'(m_ovf));
    chk("o_underflow", 32'(o_underflow), 32'(m_udf));
    chk("o_depth", 32'(o_depth), 32'(m_depth));
    chk("o_address", 32'(o_address), 32'(m_addr));
  endtask

  initial begin
    logic [AW-1:0] ra;
    int rt, pct;
    bit rpu, rpo, rs, rr;

    // Reset state, with stall also asserted to show reset wins.
    step(0, 1, 0, 1, 1, 22'h3FFFFF);
    chk("reset_valid_const", 32'(o_valid), 32'd0);
    chk("reset_depth_const", 32'(o_depth), 32'd0);

    // Basic LIFO on thread 0.
    step(1, 0, 0, 1, 0, 22'h000100);
    step(1, 0, 0, 1, 0, 22'h000200);
    step(1, 0, 0, 0, 1, '0);
    chk("lifo_first_const", 32'(o_address), 32'h200);
    step(1, 0, 0, 0, 1, '0);
    chk("lifo_second_const", 32'(o_address), 32'h100);

    // Underflow pulse on thread 2, cleared by the following idle cycle.
    step(1, 0, 2, 0, 1, '0);
    step(1, 0, 2, 0, 0, '0);

    // Thread 1: fill past capacity, drain, then one underflow.
    for (int i = 1; i <= 17; i++) step(1, 0, 1, 1, 0, AW'(i));
    chk("ovf_depth_const", 32'(o_depth), 32'd16);
    for (int i = 0; i < 17; i++) step(1, 0, 1, 0, 1, '0);

    // Interleaved threads stay independent.
    step(1, 0, 0, 1, 0, 22'h2AAAA);
    step(1, 0, 3, 1, 0, 22'h15555);
    step(1, 0, 0, 0, 1, '0);
    step(1, 0, 3, 0, 0, '0);
    step(1, 0, 3, 0, 1, '0);

    // Return-then-call replaces the top.
    step(1, 0, 0, 1, 0, 22'h00C0C);
    step(1, 0, 0, 1, 1, 22'h00D0D);
    step(1, 0, 0, 0, 1, '0);
    step(1, 0, 0, 1, 1, 22'h00E0E);   // push+pop on empty: underflow then push
    step(1, 0, 0, 0, 1, '0);

    // Stalled push, then reset mid-stall.
    step(1, 0, 0, 1, 0, 22'h0BEEF);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 22'h00E0E);
    step(0, 1, 0, 1, 1, 22'h00E0E);
    for (int t = 0; t < NT; t++) step(1, 0, t, 0, 0, '0);
    step(1, 0, 0, 0, 1, '0);

    // Randomised phases: push-heavy then pop-heavy, with stalls and rare resets.
    for (int i = 0; i < 800; i++) begin
      pct = (i % 400 < 200) ? 70 : 25;
      rt  = $urandom_range(NT - 1);
      rpu = ($urandom_range(99) < pct);
      rpo = ($urandom_range(99) < 100 - pct);
      rs  = ($urandom_range(99) < 10);
      rr  = ($urandom_range(299) != 0);
      ra  = AW'($urandom);
      step(rr, rs, rt, rpu, rpo, ra);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
